// File: rtl/anc_lms_core.sv
// Adaptive LMS FIR core: each accepted (reference, error) pair yields one anti-noise
// sample, then a weight-update pass; a single signed multiplier is shared by all taps.
module anc_lms_core #(
   parameter int TAPS = 16,
   parameter int DW   = 16,
   parameter int AW   = 40
) (
   input  logic                 S_AXI_ACLK,
   input  logic                 S_AXI_ARESETN,
   input  logic [31:0]          ctrl_port,
   input  logic [31:0]          aux_port,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] ref_in,
   input  logic signed [DW-1:0] err_in,
   output logic signed [DW-1:0] y_out,
   output logic                 out_valid,
   output logic                 busy,
   output logic [15:0]          overrun_cnt
);
   localparam int KW   = $clog2(TAPS);
   localparam int PW   = 2 * DW;
   localparam int FRAC = DW - 1;
   localparam logic [KW-1:0]        K_LAST  = KW'(TAPS - 1);
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
   localparam logic signed [DW-1:0] ZERO_DW = {DW{1'b0}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILTER = 2'd1,
      OUTPUT = 2'd2,
      UPDATE = 2'd3
   } state_t;

   // Clamp a wide signed value into the DW-bit signed range; nothing ever wraps.
   function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
      logic signed [DW-1:0] r;
      if (v > SAT_MAX) begin
         r = SAT_MAX[DW-1:0];
      end else if (v < SAT_MIN) begin
         r = SAT_MIN[DW-1:0];
      end else begin
         r = v[DW-1:0];
      end
      return r;
   endfunction

   state_t               state_r;
   logic signed [DW-1:0] x_r [TAPS];
   logic signed [DW-1:0] w_r [TAPS];
   logic signed [DW-1:0] e_l_r;
   logic signed [AW-1:0] acc_r;
   logic [KW-1:0]        k_r;
   logic signed [DW-1:0] y_r;
   logic                 out_valid_r;
   logic                 busy_r;
   logic [15:0]          overrun_r;

   logic                 enable_s;
   logic                 clear_s;
   logic                 freeze_s;
   logic [3:0]           mu_shift_s;
   logic signed [DW-1:0] gain_s;
   logic                 unused_s;
   logic signed [DW-1:0] op_a_s;
   logic signed [DW-1:0] op_b_s;
   logic signed [PW-1:0] prod_s;
   logic signed [AW-1:0] prod_ext_s;
   logic signed [DW-1:0] acc_q_s;
   logic signed [DW-1:0] y_next_s;
   logic [5:0]           upd_sh_s;
   logic signed [DW-1:0] w_next_s;

   assign enable_s   = ctrl_port[0];
   assign clear_s    = ctrl_port[1];
   assign freeze_s   = ctrl_port[2];
   assign mu_shift_s = ctrl_port[7:4];
   assign gain_s     = DW'($signed(aux_port[15:0]));
   assign unused_s   = ^{ctrl_port[31:8], ctrl_port[3], aux_port[31:16]};

   // Operand selection for the single shared multiplier, by phase.
   always_comb begin
      op_a_s = ZERO_DW;
      op_b_s = ZERO_DW;
      case (state_r)
         FILTER: begin
            op_a_s = w_r[k_r];
            op_b_s = x_r[k_r];
         end
         OUTPUT: begin
            op_a_s = acc_q_s;
            op_b_s = gain_s;
         end
         UPDATE: begin
            op_a_s = e_l_r;
            op_b_s = x_r[k_r];
         end
         default: begin
            op_a_s = ZERO_DW;
            op_b_s = ZERO_DW;
         end
      endcase
   end

   assign prod_s     = PW'(op_a_s) * PW'(op_b_s);
   assign prod_ext_s = AW'(prod_s);
   assign acc_q_s    = sat_dw(acc_r >>> FRAC);
   assign y_next_s   = sat_dw(prod_ext_s >>> FRAC);
   assign upd_sh_s   = 6'(FRAC) + {2'b00, mu_shift_s};
   assign w_next_s   = sat_dw(AW'(w_r[k_r]) + (prod_ext_s >>> upd_sh_s));

   // Sequencer: IDLE -> FILTER (TAPS MACs) -> OUTPUT -> UPDATE (TAPS weight writes).
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state_r     <= IDLE;
         for (int i = 0; i < TAPS; i++) begin
            x_r[i] <= ZERO_DW;
            w_r[i] <= ZERO_DW;
         end
         e_l_r       <= ZERO_DW;
         acc_r       <= {AW{1'b0}};
         k_r         <= {KW{1'b0}};
         y_r         <= ZERO_DW;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         overrun_r   <= 16'h0000;
      end else begin
         out_valid_r <= 1'b0;
         if (in_valid && (state_r != IDLE) && (overrun_r != 16'hFFFF)) begin
            overrun_r <= overrun_r + 16'h0001;
         end else begin
            overrun_r <= overrun_r;
         end
         case (state_r)
            IDLE: begin
               if (clear_s) begin
                  for (int i = 0; i < TAPS; i++) begin
                     x_r[i] <= ZERO_DW;
                     w_r[i] <= ZERO_DW;
                  end
               end else if (in_valid && enable_s) begin
                  for (int i = TAPS - 1; i > 0; i--) begin
                     x_r[i] <= x_r[i-1];
                  end
                  x_r[0]  <= ref_in;
                  e_l_r   <= err_in;
                  acc_r   <= {AW{1'b0}};
                  k_r     <= {KW{1'b0}};
                  state_r <= FILTER;
                  busy_r  <= 1'b1;
               end else if (in_valid) begin
                  // Disabled: answer with silence, leave the delay line alone.
                  y_r         <= ZERO_DW;
                  out_valid_r <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            FILTER: begin
               acc_r <= acc_r + prod_ext_s;
               k_r   <= k_r + KW'(1);
               if (k_r == K_LAST) begin
                  state_r <= OUTPUT;
               end else begin
                  state_r <= FILTER;
               end
            end
            OUTPUT: begin
               y_r         <= y_next_s;
               out_valid_r <= 1'b1;
               k_r         <= {KW{1'b0}};
               if (freeze_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= UPDATE;
               end
            end
            UPDATE: begin
               w_r[k_r] <= w_next_s;
               k_r      <= k_r + KW'(1);
               if (k_r == K_LAST) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= UPDATE;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign y_out       = y_r;
   assign out_valid   = out_valid_r;
   assign busy        = busy_r;
   assign overrun_cnt = overrun_r;

endmodule

// File: tb/tb_anc_lms_core.sv
// Directed bench for anc_lms_core (TAPS=16): latency, adaptation, saturation,
// overrun, clear/enable and reset behaviour against hand-computed values.
module tb_anc_lms_core;
   logic               clk;
   logic               rst_n;
   logic [31:0]        ctrl;
   logic [31:0]        aux;
   logic               in_valid;
   logic signed [15:0] ref_in;
   logic signed [15:0] err_in;
   logic signed [15:0] y_out;
   logic               out_valid;
   logic               busy;
   logic [15:0]        overrun_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   anc_lms_core #(.TAPS(16), .DW(16), .AW(40)) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .ctrl_port     (ctrl),
      .aux_port      (aux),
      .in_valid      (in_valid),
      .ref_in        (ref_in),
      .err_in        (err_in),
      .y_out         (y_out),
      .out_valid     (out_valid),
      .busy          (busy),
      .overrun_cnt   (overrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_ctrl(input logic en, input logic clr, input logic frz, input logic [3:0] mu);
      ctrl = {24'h000000, mu, 1'b0, frz, clr, en};
   endtask

   // Called at a negedge; the following posedge is the accepting edge E0.
   task automatic accept(input logic [15:0] x, input logic [15:0] e);
      in_valid = 1'b1;
      ref_in   = x;
      err_in   = e;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_sample(input logic [15:0] x, input logic [15:0] e,
                             output logic [15:0] y, output int lat);
      lat = -1;
      y   = 16'hDEAD;
      accept(x, e);
      for (int n = 1; n <= 60 && lat < 0; n++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = n;
            y   = y_out;
         end
      end
      for (int n = 0; n < 60 && busy; n++) @(negedge clk);
   endtask

   task automatic clear_weights();
      set_ctrl(1'b1, 1'b1, 1'b0, 4'd0);
      @(negedge clk);
      set_ctrl(1'b1, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic test_reset();
      logic [15:0] y;
      int lat;
      int seen;
      rst_n = 1'b0; in_valid = 1'b0; ref_in = 16'sd0; err_in = 16'sd0;
      ctrl = 32'h0000_0000; aux = 32'h0000_7FFF;
      repeat (2) @(negedge clk);
      n_cmp += 4;
      if (y_out !== 16'h0000) begin $display("FAIL rst_y: got %h want 0000", y_out); n_bad++; end
      if (out_valid !== 1'b0) begin $display("FAIL rst_ov: got %b want 0", out_valid); n_bad++; end
      if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); n_bad++; end
      if (overrun_cnt !== 16'h0000) begin $display("FAIL rst_ovr: got %h want 0000", overrun_cnt); n_bad++; end
      rst_n = 1'b1;
      set_ctrl(1'b1, 1'b0, 1'b0, 4'd0);
      run_sample(16'h4000, 16'h4000, y, lat);
      run_sample(16'h4000, 16'h0000, y, lat);
      n_cmp++;
      if (y !== 16'h0FFF) begin $display("FAIL pre_rst_y: got %h want 0fff", y); n_bad++; end
      accept(16'h4000, 16'h0000);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp += 3;
      if (y_out !== 16'h0000) begin $display("FAIL midrst_y: got %h want 0000", y_out); n_bad++; end
      if (busy !== 1'b0) begin $display("FAIL midrst_busy: got %b want 0", busy); n_bad++; end
      if (out_valid !== 1'b0) begin $display("FAIL midrst_ov: got %b want 0", out_valid); n_bad++; end
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_cmp++;
      if (seen != 0) begin $display("FAIL midrst_no_out: got %0d pulses want 0", seen); n_bad++; end
      run_sample(16'h4000, 16'h0000, y, lat);
      n_cmp += 2;
      if (y !== 16'h0000) begin $display("FAIL postrst_y: got %h want 0000", y); n_bad++; end
      if (lat != 17) begin $display("FAIL postrst_lat: got %0d want 17", lat); n_bad++; end
   endtask

   task automatic test_latency();
      logic [15:0] y;
      int lat;
      logic ov16, b16, b0;
      clear_weights();
      set_ctrl(1'b1, 1'b0, 1'b1, 4'd0);
      aux = 32'h0000_7FFF;
      accept(16'h4000, 16'h0000);
      b0 = busy;
      ov16 = 1'b1; b16 = 1'b0;
      for (int n = 1; n <= 17; n++) begin
         @(negedge clk);
         if (n == 16) begin ov16 = out_valid; b16 = busy; end
      end
      n_cmp += 6;
      if (b0 !== 1'b1) begin $display("FAIL lat_busy_e0: got %b want 1", b0); n_bad++; end
      if (ov16 !== 1'b0) begin $display("FAIL lat_ov_e16: got %b want 0", ov16); n_bad++; end
      if (b16 !== 1'b1) begin $display("FAIL lat_busy_e16: got %b want 1", b16); n_bad++; end
      if (out_valid !== 1'b1) begin $display("FAIL lat_ov_e17: got %b want 1", out_valid); n_bad++; end
      if (y_out !== 16'h0000) begin $display("FAIL lat_y: got %h want 0000", y_out); n_bad++; end
      if (busy !== 1'b0) begin $display("FAIL lat_busy_e17: got %b want 0", busy); n_bad++; end
      // Back-to-back: edge E18 must accept a new sample under freeze.
      run_sample(16'h4000, 16'h0000, y, lat);
      n_cmp += 2;
      if (lat != 17) begin $display("FAIL b2b_lat: got %0d want 17", lat); n_bad++; end
      if (overrun_cnt !== 16'h0000) begin $display("FAIL b2b_ovr: got %h want 0000", overrun_cnt); n_bad++; end
   endtask

   task automatic test_adapt();
      logic [15:0] y;
      int lat;
      clear_weights();
      aux = 32'h0000_7FFF;
      run_sample(16'h4000, 16'h4000, y, lat);
      n_cmp += 2;
      if (y !== 16'h0000) begin $display("FAIL adapt_y1: got %h want 0000", y); n_bad++; end
      if (lat != 17) begin $display("FAIL adapt_lat: got %0d want 17", lat); n_bad++; end
      run_sample(16'h4000, 16'h0000, y, lat);
      n_cmp++;
      if (y !== 16'h0FFF) begin $display("FAIL adapt_y2: got %h want 0fff", y); n_bad++; end
      aux = 32'hABCD_4000;
      run_sample(16'h4000, 16'h0000, y, lat);
      n_cmp++;
      if (y !== 16'h0800) begin $display("FAIL gain_half: got %h want 0800", y); n_bad++; end
      aux = 32'h0000_7FFF;
      clear_weights();
      set_ctrl(1'b1, 1'b0, 1'b0, 4'd1);
      run_sample(16'h4000, 16'h4000, y, lat);
      run_sample(16'h4000, 16'h0000, y, lat);
      n_cmp++;
      if (y !== 16'h07FF) begin $display("FAIL mu1_y: got %h want 07ff", y); n_bad++; end
      clear_weights();
      run_sample(16'h4000, 16'hFFFF, y, lat);
      run_sample(16'h4000, 16'h0000, y, lat);
      n_cmp++;
      if (y !== 16'hFFFF) begin $display("FAIL floor_y: got %h want ffff", y); n_bad++; end
   endtask

   task automatic test_saturation();
      logic [15:0] y;
      int lat;
      clear_weights();
      aux = 32'h0000_7FFF;
      run_sample(16'h7FFF, 16'h7FFF, y, lat);
      n_cmp++;
      if (y !== 16'h0000) begin $display("FAIL sat_y1: got %h want 0000", y); n_bad++; end
      run_sample(16'h7FFF, 16'h7FFF, y, lat);
      n_cmp++;
      if (y !== 16'h7FFC) begin $display("FAIL sat_y2: got %h want 7ffc", y); n_bad++; end
      run_sample(16'h8000, 16'h0000, y, lat);
      n_cmp++;
      if (y !== 16'hFFFE) begin $display("FAIL sat_w0_pos: got %h want fffe", y); n_bad++; end
      run_sample(16'h8000, 16'h0000, y, lat);
      n_cmp++;
      if (y !== 16'h8001) begin $display("FAIL sat_neg: got %h want 8001", y); n_bad++; end
   endtask

   task automatic test_overrun();
      logic [15:0] y;
      int lat;
      clear_weights();
      aux = 32'h0000_7FFF;
      accept(16'h4000, 16'h4000);
      y = 16'hDEAD;
      for (int n = 1; n <= 40; n++) begin
         in_valid = (n == 3) || (n == 20);
         ref_in   = 16'h7FFF;
         err_in   = 16'h7FFF;
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid) y = y_out;
      end
      n_cmp += 2;
      if (y !== 16'h0000) begin $display("FAIL ovr_y: got %h want 0000", y); n_bad++; end
      if (overrun_cnt !== 16'h0002) begin $display("FAIL ovr_cnt: got %h want 0002", overrun_cnt); n_bad++; end
      run_sample(16'h4000, 16'h0000, y, lat);
      n_cmp++;
      if (y !== 16'h0FFF) begin $display("FAIL ovr_weights: got %h want 0fff", y); n_bad++; end
   endtask

   task automatic test_clear_enable();
      logic [15:0] y;
      int lat;
      clear_weights();
      aux = 32'h0000_7FFF;
      run_sample(16'h4000, 16'h4000, y, lat);
      run_sample(16'h4000, 16'h4000, y, lat);
      n_cmp++;
      if (y !== 16'h0FFF) begin $display("FAIL ce_train_y: got %h want 0fff", y); n_bad++; end
      set_ctrl(1'b0, 1'b0, 1'b0, 4'd0);
      accept(16'h0000, 16'h7FFF);
      n_cmp += 3;
      if (out_valid !== 1'b1) begin $display("FAIL dis_ov: got %b want 1", out_valid); n_bad++; end
      if (y_out !== 16'h0000) begin $display("FAIL dis_y: got %h want 0000", y_out); n_bad++; end
      if (busy !== 1'b0) begin $display("FAIL dis_busy: got %b want 0", busy); n_bad++; end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin $display("FAIL dis_ov_width: got %b want 0", out_valid); n_bad++; end
      set_ctrl(1'b1, 1'b0, 1'b1, 4'd0);
      run_sample(16'h4000, 16'h0000, y, lat);
      n_cmp++;
      if (y !== 16'h2FFF) begin $display("FAIL dis_delay_line: got %h want 2fff", y); n_bad++; end
      set_ctrl(1'b1, 1'b0, 1'b0, 4'd0);
      accept(16'h4000, 16'h0000);
      y = 16'hDEAD;
      for (int n = 1; n <= 40; n++) begin
         if (n == 5) set_ctrl(1'b1, 1'b1, 1'b0, 4'd0);
         @(negedge clk);
         if (out_valid) y = y_out;
      end
      n_cmp++;
      if (y !== 16'h2FFF) begin $display("FAIL clr_busy_y: got %h want 2fff", y); n_bad++; end
      accept(16'h7FFF, 16'h7FFF);
      n_cmp += 2;
      if (busy !== 1'b0) begin $display("FAIL clr_drop_busy: got %b want 0", busy); n_bad++; end
      if (out_valid !== 1'b0) begin $display("FAIL clr_drop_ov: got %b want 0", out_valid); n_bad++; end
      set_ctrl(1'b1, 1'b0, 1'b0, 4'd0);
      run_sample(16'h4000, 16'h0000, y, lat);
      n_cmp += 2;
      if (y !== 16'h0000) begin $display("FAIL clr_after_y: got %h want 0000", y); n_bad++; end
      if (overrun_cnt !== 16'h0002) begin $display("FAIL clr_ovr: got %h want 0002", overrun_cnt); n_bad++; end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_adapt();
      test_saturation();
      test_overrun();
      test_clear_enable();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
